// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master.
package axil_pkg;

  localparam int AXIL_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_e;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Watchdog counter: clears on clr, counts while en, flags expired at LIMIT-1 and holds there.
module axil_timeout_cnt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic S_AXI_ACLK,
  input  logic Local_Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(LIMIT - 1));

  // NOTE: state registers use non-blocking assignments and an asynchronous reset,
  // so every flop clears the moment Local_Reset rises, independent of the clock.
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axil_cfg_master.sv
// AXI4-Lite single-outstanding initiator driven by a cmd/rsp valid-ready port.
// Define AXIL_MASTER_TIMEOUT_EN to enable the transaction watchdog.
module axil_cfg_master
  import axil_pkg::*;
#(
  parameter int          C_M_AXI_DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int          C_M_AXI_ADDR_WIDTH = 9,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            Local_Reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  state_e state;
  logic   aw_done, w_done, ar_done;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic   tmo_expired;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BREADY  & M_AXI_BVALID;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RREADY  & M_AXI_RVALID;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic tmo_clr, tmo_en;

  assign tmo_clr = (state == IDLE) && cmd_valid;
  assign tmo_en  = (state == WRITE) || (state == READ);

  axil_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .Local_Reset (Local_Reset),
    .clr         (tmo_clr),
    .en          (tmo_en),
    .expired     (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      ar_done       <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_wdata;
              M_AXI_WSTRB   <= cmd_wstrb;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_BREADY  <= 1'b1;
              state         <= WRITE;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_RREADY  <= 1'b1;
              state         <= READ;
            end
          end
        end

        WRITE: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          // A B beat only counts once both address and data have been taken.
          if (b_hs && (aw_done || aw_hs) && (w_done || w_hs)) begin
            M_AXI_BREADY <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (tmo_expired) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_resp      <= RESP_SLVERR;
            rsp_rdata     <= '0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end

        READ: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            ar_done       <= 1'b1;
          end
          if (r_hs && (ar_done || ar_hs)) begin
            M_AXI_RREADY <= 1'b0;
            ar_done      <= 1'b0;
            rsp_resp     <= M_AXI_RRESP;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (tmo_expired) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            ar_done       <= 1'b0;
            rsp_resp      <= RESP_SLVERR;
            rsp_rdata     <= '0;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed testbench for axil_cfg_master with a cycle-stepped AXI4-Lite responder.
module tb_axil_cfg_master;

  logic        S_AXI_ACLK = 1'b0;
  logic        Local_Reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout, busy;
  logic [8:0]  M_AXI_AWADDR;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [8:0]  M_AXI_ARADDR;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [0:3];

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axil_cfg_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (9),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .Local_Reset   (Local_Reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Responder for one write. Cycle k=0 is the first cycle after command accept.
  // BVALID is raised once both readies have been offered, or from k=0 when early_b.
  task automatic bfm_write(input int aw_lat, input int w_lat, input bit early_b,
                           input logic [1:0] bresp, output int aw_k, output int w_k,
                           output int rsp_k, output bit hold_bad,
                           output logic [8:0] a_q, output logic [31:0] d_q);
    logic [3:0] s_q;
    aw_k = -1; w_k = -1; rsp_k = -1; hold_bad = 1'b0;
    a_q = '0; d_q = '0; s_q = '0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        rsp_k = k;
        break;
      end
      if (M_AXI_AWVALID !== (aw_k < 0)) hold_bad = 1'b1;
      if (M_AXI_WVALID  !== (w_k < 0))  hold_bad = 1'b1;
      if (M_AXI_BREADY  !== 1'b1)       hold_bad = 1'b1;
      M_AXI_AWREADY = (k >= aw_lat) && (aw_k < 0);
      M_AXI_WREADY  = (k >= w_lat) && (w_k < 0);
      M_AXI_BVALID  = early_b || ((k >= aw_lat) && (k >= w_lat));
      M_AXI_BRESP   = bresp;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_k = k; a_q = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_k = k; d_q = M_AXI_WDATA; s_q = M_AXI_WSTRB; end
      tick();
    end
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    if (aw_k >= 0 && w_k >= 0)
      for (int b = 0; b < 4; b++)
        if (s_q[b]) mem[a_q[3:2]][8*b +: 8] = d_q[8*b +: 8];
  endtask

  // Responder for one read: ARREADY from k=ar_lat, RVALID r_delay cycles after the AR handshake.
  task automatic bfm_read(input int ar_lat, input int r_delay, input logic [1:0] rresp,
                          output int ar_k, output int rsp_k, output bit hold_bad,
                          output logic [8:0] a_q);
    ar_k = -1; rsp_k = -1; hold_bad = 1'b0; a_q = '0;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        rsp_k = k;
        break;
      end
      if (M_AXI_ARVALID !== (ar_k < 0)) hold_bad = 1'b1;
      if (M_AXI_RREADY  !== 1'b1)       hold_bad = 1'b1;
      M_AXI_ARREADY = (k >= ar_lat) && (ar_k < 0);
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_k = k; a_q = M_AXI_ARADDR; end
      M_AXI_RVALID = (ar_k >= 0) && (k >= ar_k + r_delay);
      M_AXI_RDATA  = M_AXI_RVALID ? mem[a_q[3:2]] : 32'hBAD0_BAD0;
      M_AXI_RRESP  = rresp;
      tick();
    end
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
  endtask

  task automatic test_reset();
    Local_Reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({cmd_ready, busy, rsp_valid, rsp_timeout} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 1000", {cmd_ready, busy, rsp_valid, rsp_timeout});
    end
    n_tests++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_axi: got %b want 00000",
               {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    n_tests++;
    if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, rsp_rdata, rsp_resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %h want all 0",
               M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, rsp_rdata, rsp_resp);
    end
    Local_Reset = 1'b0;
    tick();
  endtask

  task automatic test_ctrl_write_read();
    int aw_k, w_k, ar_k, rsp_k;
    bit hold_bad;
    logic [8:0] a_q;
    logic [31:0] d_q;
    issue(1'b1, 9'h000, 32'h0000_0001, 4'hF);
    n_tests++;
    if ({cmd_ready, busy} !== 2'b01) begin
      n_fail++; $display("FAIL ctrl_busy: got %b want 01", {cmd_ready, busy});
    end
    bfm_write(0, 0, 1'b0, 2'b00, aw_k, w_k, rsp_k, hold_bad, a_q, d_q);
    n_tests++;
    if ({aw_k, w_k, rsp_k} !== {32'd0, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL ctrl_wr_timing: got aw=%0d w=%0d rsp=%0d want 0 0 1", aw_k, w_k, rsp_k);
    end
    n_tests++;
    if ({hold_bad, a_q, d_q} !== {1'b0, 9'h000, 32'h0000_0001}) begin
      n_fail++; $display("FAIL ctrl_wr_bus: got hold_bad=%b addr=%h data=%h", hold_bad, a_q, d_q);
    end
    n_tests++;
    if ({rsp_resp, rsp_rdata, rsp_timeout} !== {2'b00, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL ctrl_wr_rsp: got resp=%b rdata=%h tmo=%b want 00 0 0", rsp_resp, rsp_rdata, rsp_timeout);
    end
    finish_rsp();
    n_tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL ctrl_rsp_done: got %b want 01", {rsp_valid, cmd_ready});
    end
    issue(1'b0, 9'h000, 32'h0, 4'h0);
    bfm_read(0, 1, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if ({ar_k, rsp_k, hold_bad} !== {32'd0, 32'd2, 1'b0}) begin
      n_fail++; $display("FAIL ctrl_rd_latency: got ar=%0d rsp=%0d hold_bad=%b want 0 2 0", ar_k, rsp_k, hold_bad);
    end
    n_tests++;
    if ({rsp_rdata, rsp_resp} !== {32'h0000_0001, 2'b00}) begin
      n_fail++; $display("FAIL ctrl_rd_data: got %h/%b want 00000001/00", rsp_rdata, rsp_resp);
    end
    finish_rsp();
  endtask

  task automatic test_deadbeef();
    int aw_k, w_k, ar_k, rsp_k;
    bit hold_bad;
    logic [8:0] a_q;
    logic [31:0] d_q;
    issue(1'b1, 9'h004, 32'hDEAD_BEEF, 4'hF);
    bfm_write(1, 2, 1'b0, 2'b00, aw_k, w_k, rsp_k, hold_bad, a_q, d_q);
    n_tests++;
    if ({aw_k, w_k, rsp_k} !== {32'd1, 32'd2, 32'd3}) begin
      n_fail++; $display("FAIL dbf_wr_timing: got aw=%0d w=%0d rsp=%0d want 1 2 3", aw_k, w_k, rsp_k);
    end
    n_tests++;
    if (hold_bad !== 1'b0) begin
      n_fail++; $display("FAIL dbf_valid_drop: got hold_bad=%b want 0", hold_bad);
    end
    n_tests++;
    if ({a_q, d_q} !== {9'h004, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL dbf_wr_bus: got %h/%h want 004/deadbeef", a_q, d_q);
    end
    finish_rsp();
    issue(1'b0, 9'h004, 32'h0, 4'h0);
    bfm_read(2, 0, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if ({ar_k, rsp_k, hold_bad, a_q} !== {32'd2, 32'd3, 1'b0, 9'h004}) begin
      n_fail++; $display("FAIL dbf_rd_timing: got ar=%0d rsp=%0d hold_bad=%b addr=%h want 2 3 0 004",
                         ar_k, rsp_k, hold_bad, a_q);
    end
    n_tests++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL dbf_rd_data: got %h want deadbeef", rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_early_bvalid();
    int aw_k, w_k, ar_k, rsp_k;
    bit hold_bad;
    bit extra;
    logic [8:0] a_q;
    logic [31:0] d_q;
    issue(1'b1, 9'h008, 32'h1122_3344, 4'b0011);
    bfm_write(3, 0, 1'b1, 2'b00, aw_k, w_k, rsp_k, hold_bad, a_q, d_q);
    n_tests++;
    if ({w_k, aw_k, rsp_k, hold_bad} !== {32'd0, 32'd3, 32'd4, 1'b0}) begin
      n_fail++; $display("FAIL earlyb_timing: got w=%0d aw=%0d rsp=%0d hold_bad=%b want 0 3 4 0",
                         w_k, aw_k, rsp_k, hold_bad);
    end
    finish_rsp();
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) extra = 1'b1;
      tick();
    end
    n_tests++;
    if (extra !== 1'b0) begin
      n_fail++; $display("FAIL earlyb_single_rsp: got extra response=%b want 0", extra);
    end
    issue(1'b0, 9'h008, 32'h0, 4'h0);
    bfm_read(1, 1, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if (rsp_rdata !== 32'h0000_3344) begin
      n_fail++; $display("FAIL earlyb_strobe: got %h want 00003344", rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_slverr();
    int aw_k, w_k, ar_k, rsp_k;
    bit hold_bad;
    logic [8:0] a_q;
    logic [31:0] d_q;
    issue(1'b1, 9'h00C, 32'hCAFE_0000, 4'hF);
    bfm_write(0, 1, 1'b0, 2'b10, aw_k, w_k, rsp_k, hold_bad, a_q, d_q);
    n_tests++;
    if (rsp_resp !== 2'b10) begin
      n_fail++; $display("FAIL slverr_bresp: got %b want 10", rsp_resp);
    end
    finish_rsp();
    issue(1'b0, 9'h00C, 32'h0, 4'h0);
    bfm_read(0, 2, 2'b10, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if ({rsp_k, rsp_resp, rsp_rdata} !== {32'd3, 2'b10, 32'hCAFE_0000}) begin
      n_fail++; $display("FAIL slverr_rresp: got rsp=%0d resp=%b data=%h want 3 10 cafe0000",
                         rsp_k, rsp_resp, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_rsp_hold();
    int aw_k, w_k, ar_k, rsp_k;
    bit hold_bad;
    logic [8:0] a_q;
    logic [31:0] d_q;
    issue(1'b0, 9'h004, 32'h0, 4'h0);
    bfm_read(0, 1, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 9'h000; cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rsp_valid, rsp_rdata, cmd_ready, M_AXI_AWVALID} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL hold_cycle%0d: got valid=%b data=%h cmd_ready=%b awvalid=%b want 1 deadbeef 0 0",
                           i, rsp_valid, rsp_rdata, cmd_ready, M_AXI_AWVALID);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if ({rsp_valid, cmd_ready, M_AXI_AWVALID} !== 3'b010) begin
      n_fail++; $display("FAIL hold_release: got %b want 010", {rsp_valid, cmd_ready, M_AXI_AWVALID});
    end
    tick();
    cmd_valid = 1'b0;
    n_tests++;
    if ({M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WDATA} !== {1'b1, 9'h000, 32'hA5A5_A5A5}) begin
      n_fail++; $display("FAIL hold_pending_cmd: got %b %h %h want 1 000 a5a5a5a5",
                         M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WDATA);
    end
    bfm_write(0, 0, 1'b0, 2'b00, aw_k, w_k, rsp_k, hold_bad, a_q, d_q);
    finish_rsp();
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 9'h004, 32'h1234_5678, 4'hF);
    tick();
    n_tests++;
    if ({M_AXI_AWVALID, M_AXI_WVALID} !== 2'b11) begin
      n_fail++; $display("FAIL rst_mid_pre: got %b want 11", {M_AXI_AWVALID, M_AXI_WVALID});
    end
    #2;
    Local_Reset = 1'b1;
    #1;
    n_tests++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
         rsp_valid, busy, M_AXI_AWADDR, M_AXI_WDATA} !== '0) begin
      n_fail++; $display("FAIL rst_mid_async: got %b %h %h want all 0",
                         {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, busy},
                         M_AXI_AWADDR, M_AXI_WDATA);
    end
    tick();
    Local_Reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({cmd_ready, rsp_valid, M_AXI_AWVALID} !== 3'b100) begin
      n_fail++; $display("FAIL rst_mid_after: got %b want 100", {cmd_ready, rsp_valid, M_AXI_AWVALID});
    end
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int ar_k, rsp_k;
    bit hold_bad;
    logic [8:0] a_q;
    issue(1'b0, 9'h000, 32'h0, 4'h0);
    bfm_read(1000, 0, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if ({rsp_k, hold_bad} !== {32'd16, 1'b0}) begin
      n_fail++; $display("FAIL tmo_latency: got rsp=%0d hold_bad=%b want 16 0", rsp_k, hold_bad);
    end
    n_tests++;
    if ({rsp_resp, rsp_timeout, rsp_rdata, M_AXI_ARVALID, M_AXI_RREADY} !== {2'b10, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL tmo_rsp: got resp=%b tmo=%b data=%h arvalid=%b rready=%b want 10 1 0 0 0",
                         rsp_resp, rsp_timeout, rsp_rdata, M_AXI_ARVALID, M_AXI_RREADY);
    end
    finish_rsp();
    issue(1'b0, 9'h000, 32'h0, 4'h0);
    bfm_read(0, 1, 2'b00, ar_k, rsp_k, hold_bad, a_q);
    n_tests++;
    if ({rsp_timeout, rsp_resp, rsp_rdata} !== {1'b0, 2'b00, 32'hA5A5_A5A5}) begin
      n_fail++; $display("FAIL tmo_recover: got tmo=%b resp=%b data=%h want 0 00 a5a5a5a5",
                         rsp_timeout, rsp_resp, rsp_rdata);
    end
    finish_rsp();
  endtask
`endif

  initial begin
    Local_Reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    for (int i = 0; i < 4; i++) mem[i] = '0;

    test_reset();
    test_ctrl_write_read();
    test_deadbeef();
    test_early_bvalid();
    test_slverr();
    test_rsp_hold();
    test_reset_mid_write();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
